// File: rtl/pwm_pkg.sv
// Shared widths and types for the two-channel PWM output stage.
// Counter widths, period length and the duty word type.
package pwm_pkg;

  localparam int CNT_W   = 8;
  localparam int PRESC_W = 8;
  localparam int DEAD_W  = 4;

  typedef logic [CNT_W-1:0] duty_t;

  localparam duty_t PERIOD_MAX = duty_t'(254);

endpackage

// File: rtl/pwm_out_stage_deadband.sv
// One dead-band unit: turns a comparator bit into a complementary
// high/low pair with both outputs low for dead_time cycles per edge.
module pwm_deadband
  import pwm_pkg::*;
(
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              en,
  input  logic              cmp,
  input  logic [DEAD_W-1:0] dead_time,
  output logic              pwm_h,
  output logic              pwm_l
);

  logic              cmp_q;
  logic [DEAD_W-1:0] dt;
  logic [DEAD_W-1:0] dt_nxt;
  logic              live;

  always_comb begin
    dt_nxt = '0;
    if (en) begin
      if (cmp != cmp_q) begin
        dt_nxt = dead_time;
      end else if (dt != '0) begin
        dt_nxt = dt - 1'b1;
      end
    end
  end

  assign live = en & (dt_nxt == '0);

  // h needs cmp and l needs !cmp, so they can never overlap
  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      cmp_q <= 1'b0;
      dt    <= '0;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      cmp_q <= cmp;
      dt    <= dt_nxt;
      pwm_h <= live & cmp;
      pwm_l <= live & ~cmp;
    end
  end

endmodule

// File: rtl/pwm_out_stage.sv
// Two-channel PWM output stage: prescaler, 255-tick period counter,
// double-buffered duty shadows and registered comparators.
module pwm_out_stage
  import pwm_pkg::*;
(
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [DEAD_W-1:0]  dead_time,
  input  duty_t              duty_0,
  input  duty_t              duty_1,
  output logic               pwm_h_0,
  output logic               pwm_l_0,
  output logic               pwm_h_1,
  output logic               pwm_l_1,
  output logic               period_start
);

  logic [PRESC_W-1:0] presc_cnt;
  logic [PRESC_W-1:0] presc_nxt;
  duty_t              cnt;
  duty_t              cnt_nxt;
  duty_t              sh_0;
  duty_t              sh_1;
  duty_t              sh_0_nxt;
  duty_t              sh_1_nxt;
  logic               en_q;
  logic               first;
  logic               tick;
  logic               wrap;
  logic               ps_nxt;
  logic               cmp_0;
  logic               cmp_1;
  logic               db_en;

  assign first = enable & ~en_q;
  assign tick  = presc_cnt >= prescale;
  assign wrap  = tick & (cnt == PERIOD_MAX);
  assign db_en = enable & en_q;

  always_comb begin
    presc_nxt = '0;
    cnt_nxt   = '0;
    sh_0_nxt  = sh_0;
    sh_1_nxt  = sh_1;
    ps_nxt    = 1'b0;
    unique case (1'b1)
      ~enable: begin
      end
      first: begin
        sh_0_nxt = duty_0;
        sh_1_nxt = duty_1;
        ps_nxt   = 1'b1;
      end
      default: begin
        presc_nxt = tick ? '0 : presc_cnt + 1'b1;
        cnt_nxt   = cnt;
        if (tick) begin
          cnt_nxt = wrap ? '0 : cnt + 1'b1;
        end
        if (wrap) begin
          sh_0_nxt = duty_0;
          sh_1_nxt = duty_1;
          ps_nxt   = 1'b1;
        end
      end
    endcase
  end

  // comparators track the counter value held in the same cycle
  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      en_q         <= 1'b0;
      presc_cnt    <= '0;
      cnt          <= '0;
      sh_0         <= '0;
      sh_1         <= '0;
      cmp_0        <= 1'b0;
      cmp_1        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      en_q         <= enable;
      presc_cnt    <= presc_nxt;
      cnt          <= cnt_nxt;
      sh_0         <= sh_0_nxt;
      sh_1         <= sh_1_nxt;
      cmp_0        <= enable & (cnt_nxt < sh_0_nxt);
      cmp_1        <= enable & (cnt_nxt < sh_1_nxt);
      period_start <= ps_nxt;
    end
  end

  pwm_deadband u_db_0 (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .en        (db_en),
    .cmp       (cmp_0),
    .dead_time (dead_time),
    .pwm_h     (pwm_h_0),
    .pwm_l     (pwm_l_0)
  );

  pwm_deadband u_db_1 (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .en        (db_en),
    .cmp       (cmp_1),
    .dead_time (dead_time),
    .pwm_h     (pwm_h_1),
    .pwm_l     (pwm_l_1)
  );

endmodule

// File: tb/tb_pwm_out_stage.sv
// Bench for pwm_out_stage: behavioural model compared every cycle,
// directed period measurements, then randomized traffic.
module tb_pwm_out_stage;

  localparam int INF = 1000;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] prescale = '0;
  logic [3:0] dead_time = '0;
  logic [7:0] duty_0 = '0;
  logic [7:0] duty_1 = '0;
  logic       pwm_h_0;
  logic       pwm_l_0;
  logic       pwm_h_1;
  logic       pwm_l_1;
  logic       period_start;

  int checks = 0;
  int failures = 0;

  pwm_out_stage dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .enable       (enable),
    .prescale     (prescale),
    .dead_time    (dead_time),
    .duty_0       (duty_0),
    .duty_1       (duty_1),
    .pwm_h_0      (pwm_h_0),
    .pwm_l_0      (pwm_l_0),
    .pwm_h_1      (pwm_h_1),
    .pwm_l_1      (pwm_l_1),
    .period_start (period_start)
  );

  always #5 HCLK = ~HCLK;

  // model state: tick phase, period position, shadows, and how long
  // each ideal comparator value has been stable
  int m_sub, m_cnt, m_sh0, m_sh1, m_run0, m_run1;
  bit m_en_q, m_act, m_c0, m_c1;
  bit e_h0, e_l0, e_h1, e_l1, e_ps;
  bit started;

  always @(posedge HCLK) begin
    bit dben, n0, n1;
    int d;
    d = int'(dead_time);
    dben = !HRESETn && enable && m_en_q;
    e_h0 = dben && (m_run0 > d) && m_c0;
    e_l0 = dben && (m_run0 > d) && !m_c0;
    e_h1 = dben && (m_run1 > d) && m_c1;
    e_l1 = dben && (m_run1 > d) && !m_c1;
    if (HRESETn) begin
      m_sub = 0; m_cnt = 0; m_sh0 = 0; m_sh1 = 0;
      m_en_q = 0; m_act = 0; m_c0 = 0; m_c1 = 0;
      m_run0 = INF; m_run1 = INF;
      e_ps = 0;
      started = 1;
    end else begin
      e_ps = 0;
      if (!enable) begin
        m_act = 0; m_cnt = 0; m_sub = 0;
      end else if (!m_en_q) begin
        m_act = 1; m_cnt = 0; m_sub = 0;
        m_sh0 = int'(duty_0); m_sh1 = int'(duty_1);
        e_ps = 1;
      end else if (m_sub >= int'(prescale)) begin
        m_sub = 0;
        m_cnt = (m_cnt + 1) % 255;
        if (m_cnt == 0) begin
          m_sh0 = int'(duty_0); m_sh1 = int'(duty_1);
          e_ps = 1;
        end
      end else begin
        m_sub++;
      end
      m_en_q = enable;
      n0 = m_act && (m_cnt < m_sh0);
      n1 = m_act && (m_cnt < m_sh1);
      if (!dben) begin
        m_run0 = INF; m_run1 = INF;
      end
      m_run0 = (n0 == m_c0) ? ((m_run0 < INF) ? m_run0 + 1 : INF) : 1;
      m_run1 = (n1 == m_c1) ? ((m_run1 < INF) ? m_run1 + 1 : INF) : 1;
      m_c0 = n0; m_c1 = n1;
    end
  end

  task automatic chk(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (started) begin
      chk("pwm_h_0", pwm_h_0, e_h0);
      chk("pwm_l_0", pwm_l_0, e_l0);
      chk("pwm_h_1", pwm_h_1, e_h1);
      chk("pwm_l_1", pwm_l_1, e_l1);
      chk("period_start", period_start, e_ps);
      chk("overlap", (pwm_h_0 & pwm_l_0) | (pwm_h_1 & pwm_l_1), 1'b0);
    end
  end

  task automatic wait_ps(input int limit);
    int n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!period_start && n < limit);
    lit("wait_ps", int'(period_start), 1);
  endtask

  // window runs from the current period_start cycle up to the next one
  task automatic measure(input int chg_at, input logic [7:0] chg_val,
                         output int len, output int h0, output int l0,
                         output int h1, output int dz0);
    len = 0; h0 = 0; l0 = 0; h1 = 0; dz0 = 0;
    do begin
      if (len == chg_at) duty_1 = chg_val;
      h0 += int'(pwm_h_0);
      l0 += int'(pwm_l_0);
      h1 += int'(pwm_h_1);
      dz0 += int'(!pwm_h_0 && !pwm_l_0);
      @(negedge HCLK);
      len++;
    end while (!period_start && len < 5000);
    if (!period_start) lit("measure_timeout", len, -1);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0: return 8'd0;
      1: return 8'd255;
      2: return 8'd1;
      3: return 8'd254;
      default: return 8'($urandom);
    endcase
  endfunction

  int sw[3] = '{0, 128, 255};
  int len, h0, l0, h1, dz;

  initial begin
    repeat (3) @(negedge HCLK);
    lit("rst_h0", int'(pwm_h_0), 0);
    lit("rst_l0", int'(pwm_l_0), 0);
    lit("rst_h1", int'(pwm_h_1), 0);
    lit("rst_l1", int'(pwm_l_1), 0);
    lit("rst_ps", int'(period_start), 0);

    HRESETn = 0; enable = 1; duty_0 = 128; duty_1 = 64;
    @(negedge HCLK);
    lit("first_ps", int'(period_start), 1);
    repeat (20) @(negedge HCLK);
    lit("h0_high", int'(pwm_h_0), 1);
    HRESETn = 1;
    @(negedge HCLK);
    lit("midrst_h0", int'(pwm_h_0), 0);
    lit("midrst_any", int'(pwm_l_0 | pwm_h_1 | pwm_l_1), 0);
    HRESETn = 0;
    @(negedge HCLK);
    lit("ps_after_rst", int'(period_start), 1);

    for (int i = 0; i < 3; i++) begin
      duty_0 = 8'(sw[i]);
      wait_ps(600);
      measure(-1, 8'd0, len, h0, l0, h1, dz);
      measure(-1, 8'd0, len, h0, l0, h1, dz);
      lit("sweep_hi", h0, sw[i]);
      lit("sweep_lo", l0, 255 - sw[i]);
      lit("sweep_len", len, 255);
    end

    wait_ps(600);
    measure(10, 8'd200, len, h0, l0, h1, dz);
    lit("shadow_old", h1, 64);
    measure(-1, 8'd0, len, h0, l0, h1, dz);
    lit("shadow_new", h1, 200);

    enable = 0; dead_time = 3; duty_0 = 100;
    @(negedge HCLK);
    enable = 1;
    wait_ps(10);
    measure(-1, 8'd0, len, h0, l0, h1, dz);
    measure(-1, 8'd0, len, h0, l0, h1, dz);
    lit("dead_hi", h0, 97);
    lit("dead_lo", l0, 152);
    lit("dead_zero", dz, 6);

    enable = 0; dead_time = 0; prescale = 3; duty_0 = 10;
    @(negedge HCLK);
    enable = 1;
    wait_ps(10);
    measure(-1, 8'd0, len, h0, l0, h1, dz);
    measure(-1, 8'd0, len, h0, l0, h1, dz);
    lit("presc_len", len, 1020);
    lit("presc_hi", h0, 40);
    lit("presc_lo", l0, 980);

    enable = 0; prescale = 200; duty_0 = 1;
    @(negedge HCLK);
    enable = 1;
    wait_ps(10);
    repeat (150) @(negedge HCLK);
    lit("slow_h0", int'(pwm_h_0), 1);
    prescale = 2;
    @(negedge HCLK);
    lit("tick_h0", int'(pwm_h_0), 1);
    @(negedge HCLK);
    lit("after_tick_h0", int'(pwm_h_0), 0);
    lit("after_tick_l0", int'(pwm_l_0), 1);

    enable = 0; prescale = 0; duty_0 = 77;
    @(negedge HCLK);
    enable = 1;
    wait_ps(10);
    repeat (254) @(negedge HCLK);
    enable = 0;
    @(negedge HCLK);
    lit("wrapdis_ps", int'(period_start), 0);
    lit("wrapdis_out", int'(pwm_h_0 | pwm_l_0 | pwm_h_1 | pwm_l_1), 0);
    duty_0 = 50; enable = 1;
    @(negedge HCLK);
    lit("reen_ps", int'(period_start), 1);
    measure(-1, 8'd0, len, h0, l0, h1, dz);
    lit("reen_hi", h0, 50);

    enable = 0; dead_time = 2;
    for (int i = 0; i < 6000; i++) begin
      @(negedge HCLK);
      HRESETn = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 7) == 0) duty_0 = pick();
      if ($urandom_range(0, 7) == 0) duty_1 = pick();
      if ($urandom_range(0, 199) == 0) prescale = 8'($urandom_range(0, 3));
      if (!enable) begin
        if ($urandom_range(0, 9) == 0) enable = 1;
      end else if ($urandom_range(0, 299) == 0) begin
        enable = 0;
        dead_time = 4'($urandom_range(0, 15));
      end
    end
    HRESETn = 0;
    @(negedge HCLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_out_stage.md
# pwm_out_stage

Two-channel PWM output stage sitting directly downstream of the HLS PID accelerator's AHB wrapper. Consumes the 8-bit duty words `dout_0_pid`/`dout_1_pid` and turns each into a complementary high/low gate-drive pair. Duty is double-buffered so updates land only on period boundaries, and programmable dead-time is inserted between complementary edges.

## Interface
- `CNT_W`, 8: duty and period counter width.
- `PRESC_W`, 8: prescaler width.
- `DEAD_W`, 4: dead-time counter width, in HCLK cycles.
- `HCLK`  in  1  sole clock; all logic is on the rising edge.
- `HRESETn`  in  1  reset; synchronous and active-high (asserted = 1).
- `enable`  in  1  run control; 0 holds the stage idle with all outputs low.
- `prescale`  in  PRESC_W  one tick every `prescale+1` HCLK cycles.
- `dead_time`  in  DEAD_W  dead-time length D, in HCLK cycles.
- `duty_0`, `duty_1`  in  CNT_W  duty words, fed from `dout_0_pid`/`dout_1_pid`.
- `pwm_h_0`, `pwm_l_0`, `pwm_h_1`, `pwm_l_1`  out  1 each  complementary gate drives.
- `period_start`  out  1  one-cycle pulse on the first cycle of each period.

## Operation
- Prescaler `presc_cnt`:
  - When `presc_cnt >= prescale`: `tick`=1 and `presc_cnt`←0; otherwise `presc_cnt` increments.
  - `prescale`=0 gives a tick every cycle.
  - A change to `prescale` takes effect immediately; the `>=` comparison guarantees no long wrap.
- Period counter `cnt`:
  - Advances on each tick, 0..254, then wraps to 0.
  - Period = 255 ticks.
- Shadow duty `sh_n`:
  - Loaded from `duty_n` on every tick where `cnt`==254 (wrap).
  - Also loaded on the first enabled cycle after `enable` was 0.
  - A duty change mid-period is ignored until the next wrap.
- Comparator `cmp_n` is registered: `cmp_n` = (`cnt` < `sh_n`).
  - `sh_n`=0 gives 0 % duty; `sh_n`=255 gives 100 % duty.
- Dead-band, per channel:
  - Any change of `cmp_n` loads `dt_n`←D and forces both outputs of that channel low.
  - `dt_n` decrements to 0. While `dt_n`==0: `pwm_h_n`=`cmp_n` and `pwm_l_n`=!`cmp_n`.
  - A `cmp_n` toggle while `dt_n`≠0 reloads D; both outputs stay low.
  - `pwm_h_n` and `pwm_l_n` are never 1 simultaneously, under any input sequence.
- `period_start` pulses for one cycle when `cnt` enters 0, including the first period after enable.
- `enable`=0:
  - `presc_cnt`, `cnt` and `dt_n` are held at 0.
  - All outputs are driven 0 from the next edge.
  - `enable` falling on the same cycle as a wrap: `enable` wins; no shadow load, no pulse.
- Reset:
  - All counters, shadows and `cmp_n` are cleared to 0.
  - Every output is 0 on the cycle after `HRESETn` is sampled 1, including mid-period and mid-dead-time.

## Timing
- All outputs are registered. Reset values: all four `pwm_*` = 0, `period_start` = 0.
- Enable to first `period_start`: `enable` sampled 1 at edge t gives `period_start`=1 in cycle t+1; `sh_n` holds `duty_n` as sampled at t.
- Comparator change to outputs:
  - The outgoing output drops 1 cycle after `cmp_n` changes.
  - The incoming output rises D+1 cycles after the change; for D=0 it rises 1 cycle after.
- Wrap: the tick with `cnt`==254 loads the shadow, and `period_start` follows on the next cycle.
- The high phase lasts `sh_n`×(`prescale`+1) HCLK cycles, minus D on the rising side.

## Structure
- Package `pwm_pkg`: `CNT_W`, `PRESC_W`, `DEAD_W`, `PERIOD_MAX`=254, and a typedef `duty_t` (logic [CNT_W-1:0]).
- Sub-module `pwm_deadband`: one comparator-to-complementary-pair dead-band unit, holding `dt` and the output registers. Instantiated twice.
- The top level holds the prescaler, period counter, shadows, comparators and `period_start`.

## Test plan
- Reset mid-operation: assert `HRESETn`=1 during a high phase → all outputs 0 on the next cycle; after reset release with `enable`=1, the first `period_start` occurs 1 cycle later.
- Duty sweep: `prescale`=0, D=0; set `duty_0` to 0, 128, 255 in turn → `pwm_h_0` high for exactly 0, 128 and 255 cycles of each 255-cycle period; `pwm_l_0` is the exact complement.
- Shadowing: `duty_1`=64, then change it to 200 at `cnt`=10 → the current period stays at 64 high ticks; the next period has 200.
- Dead-time: D=3, `duty_0`=100 → after each edge, both outputs are low for exactly 3 cycles; a `pwm_h_0`&`pwm_l_0` assertion never fires.
- Prescale: `prescale`=3 → each period is 1020 HCLK cycles and `duty_0`=10 gives 40 high cycles; changing `prescale` from 200 to 2 while `presc_cnt`=150 produces a tick on the next cycle.
- Enable: drop `enable` on the wrap cycle → no `period_start` and outputs go 0; re-raise it with `duty_0`=50 → the first period uses 50.
